// File: rtl/data_mem_if.sv
// Request/response bundle between the core's data port and the memory responder.
interface data_mem_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_sign;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_size, req_sign,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_size, req_sign,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Multi-cycle backing store for the core's data port: one access in flight,
// WAIT_STATES extra cycles between accept and a single-cycle response pulse.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | ready for a request; req_ready high
// WAIT  | request latched, wait-state down-counter running
// RESP  | access committed on entry; resp_valid high for this cycle
module data_mem_responder #(
  parameter int DEPTH_LOG2  = 8,
  parameter int WAIT_STATES = 2
) (
  input logic         clk,
  input logic         rst_n,
  data_mem_if.slave   bus_if
);

  localparam int         DEPTH   = 1 << DEPTH_LOG2;
  localparam logic [3:0] WAIT_LD = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        accept;
  logic        commit;

  logic        write_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [1:0]  size_q;
  logic        sign_q;

  logic        resp_valid_q;
  logic [31:0] resp_rdata_q;
  logic        resp_err_q;

  logic [31:0] mem_q [DEPTH];

  // Effective operation: with zero wait states the commit edge is the accept
  // edge, so the live inputs must be used instead of the latched copy.
  logic                  op_write;
  logic [31:0]           op_addr;
  logic [31:0]           op_wdata;
  logic [1:0]            op_size;
  logic                  op_sign;
  logic                  op_err;
  logic [DEPTH_LOG2-1:0] op_idx;
  logic [3:0]            wr_be;
  logic [31:0]           wr_data;
  logic [31:0]           rd_word;
  logic [31:0]           rd_shift;
  logic [31:0]           rd_ext;
  logic                  unused_addr_hi;

  assign op_write = (state_q == S_IDLE) ? bus_if.req_write : write_q;
  assign op_addr  = (state_q == S_IDLE) ? bus_if.req_addr  : addr_q;
  assign op_wdata = (state_q == S_IDLE) ? bus_if.req_wdata : wdata_q;
  assign op_size  = (state_q == S_IDLE) ? bus_if.req_size  : size_q;
  assign op_sign  = (state_q == S_IDLE) ? bus_if.req_sign  : sign_q;

  assign op_idx         = op_addr[DEPTH_LOG2+1:2];
  assign unused_addr_hi = ^op_addr[31:DEPTH_LOG2+2];

  assign op_err = (op_size == 2'd3) ||
                  ((op_size == 2'd1) && op_addr[0]) ||
                  ((op_size == 2'd2) && (op_addr[1:0] != 2'b00));

  // FSM state and wait-state counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; commit marks the edge that enters RESP
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    commit  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus_if.req_valid) begin
          accept = 1'b1;
          cnt_d  = WAIT_LD;
          if (WAIT_STATES == 0) begin
            state_d = S_RESP;
            commit  = rst_n;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = S_RESP;
          commit  = rst_n;
        end
      end
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Request capture at accept; later input changes are ignored
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_q <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      size_q  <= 2'd0;
      sign_q  <= 1'b0;
    end else if (accept) begin
      write_q <= bus_if.req_write;
      addr_q  <= bus_if.req_addr;
      wdata_q <= bus_if.req_wdata;
      size_q  <= bus_if.req_size;
      sign_q  <= bus_if.req_sign;
    end
  end

  // Store lane enables and replicated store data (little-endian lanes)
  always_comb begin
    wr_be   = 4'b0000;
    wr_data = op_wdata;
    unique case (op_size)
      2'd0: begin
        wr_be   = 4'b0001 << op_addr[1:0];
        wr_data = {4{op_wdata[7:0]}};
      end
      2'd1: begin
        wr_be   = op_addr[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{op_wdata[15:0]}};
      end
      2'd2: wr_be = 4'b1111;
      default: wr_be = 4'b0000;
    endcase
  end

  // Load alignment and sign/zero extension
  always_comb begin
    rd_word  = mem_q[op_idx];
    rd_shift = rd_word >> {op_addr[1:0], 3'b000};
    rd_ext   = 32'd0;
    unique case (op_size)
      2'd0:    rd_ext = {{24{op_sign & rd_shift[7]}},  rd_shift[7:0]};
      2'd1:    rd_ext = {{16{op_sign & rd_shift[15]}}, rd_shift[15:0]};
      2'd2:    rd_ext = rd_word;
      default: rd_ext = 32'd0;
    endcase
  end

  // Memory array, byte-lane writes on the commit edge; contents survive reset
  always_ff @(posedge clk) begin
    if (commit && op_write && !op_err) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) mem_q[op_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  // Response registers: pulse on commit, data and error held until the next one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'd0;
      resp_err_q   <= 1'b0;
    end else begin
      resp_valid_q <= commit;
      if (commit) begin
        resp_err_q   <= op_err;
        resp_rdata_q <= (op_err || op_write) ? 32'd0 : rd_ext;
      end
    end
  end

  assign bus_if.req_ready  = (state_q == S_IDLE);
  assign bus_if.resp_valid = resp_valid_q;
  assign bus_if.resp_rdata = resp_rdata_q;
  assign bus_if.resp_err   = resp_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: two instances (2 and 0 wait states) checked
// against a byte-addressed reference memory.
module tb_data_mem_responder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic        t_sel = 1'b0;
  logic        t_valid = 1'b0;
  logic        t_write = 1'b0;
  logic [31:0] t_addr = 32'd0;
  logic [31:0] t_wdata = 32'd0;
  logic [1:0]  t_size = 2'd0;
  logic        t_sign = 1'b0;

  int n_pass = 0;
  int n_total = 0;

  logic [7:0] refm [2][1024];

  always #5 clk = ~clk;

  data_mem_if if2();
  data_mem_if if0();

  assign if2.req_valid = t_valid & ~t_sel;
  assign if0.req_valid = t_valid &  t_sel;
  assign if2.req_write = t_write;
  assign if0.req_write = t_write;
  assign if2.req_addr  = t_addr;
  assign if0.req_addr  = t_addr;
  assign if2.req_wdata = t_wdata;
  assign if0.req_wdata = t_wdata;
  assign if2.req_size  = t_size;
  assign if0.req_size  = t_size;
  assign if2.req_sign  = t_sign;
  assign if0.req_sign  = t_sign;

  wire        obs_ready  = t_sel ? if0.req_ready  : if2.req_ready;
  wire        obs_rvalid = t_sel ? if0.resp_valid : if2.resp_valid;
  wire [31:0] obs_rdata  = t_sel ? if0.resp_rdata : if2.resp_rdata;
  wire        obs_err    = t_sel ? if0.resp_err   : if2.resp_err;

  data_mem_responder #(.DEPTH_LOG2(8), .WAIT_STATES(2)) u_dut_w2 (
    .clk(clk), .rst_n(rst_n), .bus_if(if2)
  );
  data_mem_responder #(.DEPTH_LOG2(8), .WAIT_STATES(0)) u_dut_w0 (
    .clk(clk), .rst_n(rst_n), .bus_if(if0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Reference: 1 KiB byte memory per instance, address taken modulo 1024
  function automatic void model(input bit s, input bit wr, input logic [31:0] a,
                                input logic [31:0] wd, input logic [1:0] sz, input bit sg,
                                output logic [31:0] rd, output logic e);
    int nb;
    int base;
    e  = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00);
    rd = 32'd0;
    if (e) return;
    nb   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    base = int'(a[9:0]);
    if (wr) begin
      for (int i = 0; i < nb; i++) refm[s][base+i] = wd[8*i +: 8];
    end else begin
      for (int i = 0; i < nb; i++) rd[8*i +: 8] = refm[s][base+i];
      if (sg && nb < 4 && rd[8*nb-1]) rd = rd | (32'hFFFF_FFFF << (8*nb));
    end
  endfunction

  // One complete transaction on the selected instance, fully checked
  task automatic xfer(input bit sel, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                      input logic [1:0] sz, input bit sg, output logic [31:0] rd, output logic e);
    logic [31:0] exp_rd;
    logic        exp_e;
    int          lat;
    int          w;
    bit          ready_low;
    w = sel ? 0 : 2;
    model(sel, wr, a, wd, sz, sg, exp_rd, exp_e);
    t_sel = sel; t_write = wr; t_addr = a; t_wdata = wd; t_size = sz; t_sign = sg;
    t_valid = 1'b1;
    #1;
    lat = 0;
    while (!obs_ready && lat < 50) begin @(posedge clk); #1; lat++; end
    chk("ready_idle", obs_ready, 1);
    @(posedge clk); #1;
    t_valid = 1'b0;
    t_write = 1'($urandom); t_addr = $urandom; t_wdata = $urandom;
    t_size = 2'($urandom); t_sign = 1'($urandom);
    lat = 1;
    ready_low = 1'b1;
    while (!obs_rvalid && lat < 50) begin
      if (obs_ready) ready_low = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    if (obs_ready) ready_low = 1'b0;
    chk("latency", lat, w + 1);
    chk("ready_busy", ready_low, 1);
    chk("rdata", obs_rdata, exp_rd);
    chk("err", obs_err, exp_e);
    rd = obs_rdata;
    e  = obs_err;
    @(posedge clk); #1;
    chk("pulse_one_cycle", obs_rvalid, 0);
    chk("rdata_hold", obs_rdata, exp_rd);
    chk("err_hold", obs_err, exp_e);
    chk("ready_back", obs_ready, 1);
  endtask

  initial begin
    logic [31:0] rd;
    logic        e;
    bit          saw;
    bit          s;
    logic [1:0]  sz;

    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      t_sel = 1'(k);
      #1;
      chk("rst_ready", obs_ready, 1);
      chk("rst_resp_valid", obs_rvalid, 0);
      chk("rst_rdata", obs_rdata, 0);
      chk("rst_err", obs_err, 0);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Give every word a known value in both instances
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 256; i++)
        xfer(1'(k), 1'b1, 32'(i * 4), $urandom, 2'd2, 1'b0, rd, e);

    // Word store/load
    xfer(0, 1, 32'h10, 32'hDEADBEEF, 2'd2, 0, rd, e);
    xfer(0, 0, 32'h10, 32'h0, 2'd2, 0, rd, e);
    chk("s1_word", rd, 32'hDEADBEEF);
    chk("s1_err", e, 0);

    // Byte store, signed/unsigned byte loads
    xfer(0, 1, 32'h13, 32'h80, 2'd0, 0, rd, e);
    xfer(0, 0, 32'h13, 32'h0, 2'd0, 1, rd, e);
    chk("s2_byte_signed", rd, 32'hFFFFFF80);
    xfer(0, 0, 32'h13, 32'h0, 2'd0, 0, rd, e);
    chk("s2_byte_unsigned", rd, 32'h00000080);
    xfer(0, 0, 32'h10, 32'h0, 2'd2, 1, rd, e);
    chk("s2_word_merge", rd, 32'h80ADBEEF);

    // Half store/load and misaligned half
    xfer(0, 1, 32'h16, 32'h8001, 2'd1, 0, rd, e);
    xfer(0, 0, 32'h16, 32'h0, 2'd1, 1, rd, e);
    chk("s3_half_signed", rd, 32'hFFFF8001);
    xfer(0, 0, 32'h17, 32'h0, 2'd1, 1, rd, e);
    chk("s3_misaligned_err", e, 1);
    chk("s3_misaligned_rdata", rd, 0);
    xfer(0, 0, 32'h16, 32'h0, 2'd1, 0, rd, e);
    chk("s3_unchanged", rd, 32'h00008001);

    // Misaligned word store and illegal size
    xfer(0, 1, 32'h11, 32'hCAFEF00D, 2'd2, 0, rd, e);
    chk("s4_word_misaligned_err", e, 1);
    xfer(0, 1, 32'h10, 32'h11111111, 2'd3, 0, rd, e);
    chk("s4_size3_err", e, 1);
    xfer(0, 0, 32'h10, 32'h0, 2'd2, 0, rd, e);
    chk("s4_prior_value", rd, 32'h80ADBEEF);

    // Address wrap
    xfer(0, 1, 32'h400, 32'h12345678, 2'd2, 0, rd, e);
    xfer(0, 0, 32'h000, 32'h0, 2'd2, 0, rd, e);
    chk("s5_wrap", rd, 32'h12345678);

    // Reset one cycle after accepting a store: store is dropped, no response
    t_sel = 1'b0; t_write = 1'b1; t_addr = 32'h20; t_wdata = 32'hA5A5A5A5;
    t_size = 2'd2; t_sign = 1'b0; t_valid = 1'b1;
    #1;
    @(posedge clk); #1;
    t_valid = 1'b0;
    chk("abort_accepted", obs_ready, 0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    saw = obs_rvalid;
    repeat (3) begin @(posedge clk); #1; if (obs_rvalid) saw = 1'b1; end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    if (obs_rvalid) saw = 1'b1;
    chk("abort_no_resp", saw, 0);
    chk("abort_ready", obs_ready, 1);
    xfer(0, 0, 32'h20, 32'h0, 2'd2, 0, rd, e);

    // Zero wait states
    xfer(1, 1, 32'h10, 32'hDEADBEEF, 2'd2, 0, rd, e);
    xfer(1, 0, 32'h10, 32'h0, 2'd2, 0, rd, e);
    chk("w0_word", rd, 32'hDEADBEEF);

    // Random mix on both instances
    for (int i = 0; i < 400; i++) begin
      s  = 1'($urandom);
      sz = 2'($urandom_range(0, 3));
      xfer(s, 1'($urandom), $urandom, $urandom, sz, 1'($urandom), rd, e);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
